iomem_timer: RTL

IOMEM_TIMER -- requirements
Module: iomem_timer

---
 rtl/iomem_timer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/iomem_timer.sv
// Memory-mapped down-counting timer on a valid/ready iomem bus.
// Registers CTRL, PRESCALE, COUNT and RELOAD are selected by iomem_addr[3:2].
module iomem_timer #(
    parameter logic [7:0] ADDR_HI = 8'h04
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        iomem_valid,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic        iomem_ready,
    output logic [31:0] iomem_rdata,
    output logic        irq
);
    localparam logic [1:0] OFF_CTRL     = 2'd0;
    localparam logic [1:0] OFF_PRESCALE = 2'd1;
    localparam logic [1:0] OFF_COUNT    = 2'd2;
    localparam logic [1:0] OFF_RELOAD   = 2'd3;

    // Replace only the byte lanes whose strobe bit is set.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_val[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_val[8*i +: 8];
            end
        end
        return res;
    endfunction

    logic        ready_r;
    logic [31:0] rdata_r;
    logic        irq_r;
    logic        ctrl_en_r;
    logic        ctrl_auto_r;
    logic        ctrl_irq_en_r;
    logic        expired_r;
    logic [15:0] prescale_r;
    logic [31:0] count_r;
    logic [31:0] reload_r;
    logic [15:0] pcnt_r;

    logic        sel_s;
    logic        wr_s;
    logic [1:0]  off_s;
    logic        tick_s;
    logic        expire_set_s;
    logic [31:0] prescale_wr_s;
    logic [31:0] rd_val_s;
    logic [31:0] count_next_s;
    logic        expired_next_s;
    logic [15:0] pcnt_next_s;
    logic        unused_bits_s;

    assign sel_s         = iomem_valid && !ready_r && (iomem_addr[31:24] == ADDR_HI);
    assign wr_s          = sel_s && (iomem_wstrb != 4'b0000);
    assign off_s         = iomem_addr[3:2];
    assign tick_s        = ctrl_en_r && (pcnt_r == prescale_r);
    assign expire_set_s  = tick_s && (count_r == 32'd1);
    assign prescale_wr_s = merge_lanes({16'h0000, prescale_r}, iomem_wdata, iomem_wstrb);
    assign unused_bits_s = ^{iomem_addr[23:4], iomem_addr[1:0], prescale_wr_s[31:16]};

    // Register read mux; the value is captured before any write lands.
    always_comb begin
        rd_val_s = 32'h0000_0000;
        case (off_s)
            OFF_CTRL:     rd_val_s = {23'd0, expired_r, 5'd0, ctrl_irq_en_r, ctrl_auto_r, ctrl_en_r};
            OFF_PRESCALE: rd_val_s = {16'h0000, prescale_r};
            OFF_COUNT:    rd_val_s = count_r;
            OFF_RELOAD:   rd_val_s = reload_r;
            default:      rd_val_s = 32'h0000_0000;
        endcase
    end

    // Next-state for the counter, EXPIRED flag and prescaler; bus writes to COUNT beat the tick.
    always_comb begin
        count_next_s   = count_r;
        expired_next_s = expired_r;
        pcnt_next_s    = pcnt_r;
        if (wr_s && (off_s == OFF_COUNT)) begin
            count_next_s = merge_lanes(count_r, iomem_wdata, iomem_wstrb);
        end else if (tick_s && (count_r > 32'd1)) begin
            count_next_s = count_r - 32'd1;
        end else if (expire_set_s) begin
            count_next_s = ctrl_auto_r ? reload_r : 32'd0;
        end else begin
            count_next_s = count_r;
        end

        if (expire_set_s) begin
            expired_next_s = 1'b1;
        end else if (wr_s && (off_s == OFF_CTRL) && iomem_wstrb[1] && iomem_wdata[8]) begin
            expired_next_s = 1'b0;
        end else begin
            expired_next_s = expired_r;
        end

        if (!ctrl_en_r) begin
            pcnt_next_s = 16'd0;
        end else if (wr_s && (off_s == OFF_PRESCALE)) begin
            pcnt_next_s = 16'd0;
        end else if (tick_s) begin
            pcnt_next_s = 16'd0;
        end else begin
            pcnt_next_s = pcnt_r + 16'd1;
        end
    end

    // State and bus response registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ready_r       <= 1'b0;
            rdata_r       <= 32'h0000_0000;
            irq_r         <= 1'b0;
            ctrl_en_r     <= 1'b0;
            ctrl_auto_r   <= 1'b0;
            ctrl_irq_en_r <= 1'b0;
            expired_r     <= 1'b0;
            prescale_r    <= 16'd0;
            count_r       <= 32'd0;
            reload_r      <= 32'd0;
            pcnt_r        <= 16'd0;
        end else begin
            ready_r   <= sel_s;
            rdata_r   <= sel_s ? rd_val_s : 32'h0000_0000;
            irq_r     <= expired_r && ctrl_irq_en_r;
            count_r   <= count_next_s;
            expired_r <= expired_next_s;
            pcnt_r    <= pcnt_next_s;
            if (wr_s && (off_s == OFF_CTRL) && iomem_wstrb[0]) begin
                ctrl_en_r     <= iomem_wdata[0];
                ctrl_auto_r   <= iomem_wdata[1];
                ctrl_irq_en_r <= iomem_wdata[2];
            end
            if (wr_s && (off_s == OFF_PRESCALE)) begin
                prescale_r <= prescale_wr_s[15:0];
            end
            if (wr_s && (off_s == OFF_RELOAD)) begin
                reload_r <= merge_lanes(reload_r, iomem_wdata, iomem_wstrb);
            end
        end
    end

    assign iomem_ready = ready_r;
    assign iomem_rdata = rdata_r;
    assign irq         = irq_r;
endmodule
